// File: rtl/sram_multitap_delay_line.sv
// Circular sample buffer with NUM_TAPS programmable read taps sharing one
// synchronous read port; unwritten history reads as zero, early strobes flag overrun.
module sram_multitap_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_TAPS   = 2
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           sample_valid_i,
  input  logic [DATA_WIDTH-1:0]          sample_i,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_i,
  input  logic                           overrun_clr_i,
  output logic                           busy_o,
  output logic                           taps_valid_o,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] taps_o,
  output logic                           overrun_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(NUM_TAPS + 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]          mem [DEPTH];
  logic [ADDR_WIDTH-1:0]          wr_ptr;
  logic [ADDR_WIDTH-1:0]          base;
  logic [ADDR_WIDTH-1:0]          rd_addr;
  logic [ADDR_WIDTH:0]            fill;
  logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_q;
  logic [CW-1:0]                  cnt;
  logic                           rd_zero;
  logic [ADDR_WIDTH-1:0]          cur_delay;
  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_acc;
  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_next;
  logic                           accept;
  logic                           issue;
  logic                           capture;
  logic                           last;

  // cnt counts taps issued; capture of tap k happens while cnt == k+1.
  assign accept  = sample_valid_i && (state_q != READ);
  assign issue   = (state_q == READ) && (int'(cnt) < NUM_TAPS);
  assign capture = (state_q == READ) && (cnt != '0);
  assign last    = (state_q == READ) && (int'(cnt) == NUM_TAPS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (last) state_d = DONE;
      DONE:    state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_delay = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (int'(cnt) == k) cur_delay = delay_q[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    tap_next = tap_acc;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (capture && (int'(cnt) == k + 1)) begin
        tap_next[k*DATA_WIDTH +: DATA_WIDTH] = rd_zero ? '0 : mem[rd_addr];
      end
    end
  end

  // Memory has no reset; the fill counter provides zero history instead.
  always_ff @(posedge wb_clk_i) begin
    if (accept && !wb_rst_i) mem[wr_ptr] <= sample_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      fill         <= '0;
      base         <= '0;
      rd_addr      <= '0;
      delay_q      <= '0;
      cnt          <= '0;
      rd_zero      <= 1'b0;
      tap_acc      <= '0;
      taps_o       <= '0;
      taps_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_valid_o <= 1'b0;
      if (accept) begin
        delay_q <= delay_i;
        base    <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
        if (!fill[ADDR_WIDTH]) fill <= fill + 1'b1;
        cnt     <= '0;
        busy_o  <= 1'b1;
      end
      if (state_q == READ) begin
        cnt     <= cnt + 1'b1;
        tap_acc <= tap_next;
      end
      if (issue) begin
        rd_addr <= base - cur_delay;
        rd_zero <= ({1'b0, cur_delay} >= fill);
      end
      if (last) begin
        taps_o       <= tap_next;
        taps_valid_o <= 1'b1;
        busy_o       <= 1'b0;
      end
      if (sample_valid_i && busy_o) overrun_o <= 1'b1;
      else if (overrun_clr_i)       overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_multitap_delay_line.sv
// Directed bench for sram_multitap_delay_line with a 16-deep buffer and two taps.
module tb_sram_multitap_delay_line;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NT = 2;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              sample_valid_i;
  logic [DW-1:0]     sample_i;
  logic [NT*AW-1:0]  delay_i;
  logic              overrun_clr_i;
  logic              busy_o;
  logic              taps_valid_o;
  logic [NT*DW-1:0]  taps_o;
  logic              overrun_o;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  sram_multitap_delay_line #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .delay_i        (delay_i),
    .overrun_clr_i  (overrun_clr_i),
    .busy_o         (busy_o),
    .taps_valid_o   (taps_valid_o),
    .taps_o         (taps_o),
    .overrun_o      (overrun_o)
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;
  endtask

  task automatic strobe(input logic [DW-1:0] s, input logic [NT*AW-1:0] d);
    sample_i       = s;
    delay_i        = d;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (taps_valid_o !== 1'b1 && cyc < 16) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) tick();
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++;
    if (taps_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", taps_valid_o); end
    total++;
    if (taps_o !== '0) begin bad++; $display("FAIL reset_taps got=%h exp=0", taps_o); end
    total++;
    if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
  endtask

  task automatic test_delay_taps();
    logic [DW-1:0] exp1 [5];
    logic [NT*DW-1:0] exp_t;
    int cyc;
    exp1[0] = 16'h0000; exp1[1] = 16'h0000; exp1[2] = 16'h0000;
    exp1[3] = 16'h0001; exp1[4] = 16'h0002;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe(DW'(i + 1), 8'h30);
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL delay_busy[%0d] got=%b exp=1", i, busy_o); end
      wait_valid(cyc);
      total++;
      if (cyc !== 3) begin bad++; $display("FAIL delay_latency[%0d] got=%0d exp=3", i, cyc); end
      exp_t = {exp1[i], DW'(i + 1)};
      total++;
      if (taps_o !== exp_t) begin bad++; $display("FAIL delay_taps[%0d] got=%h exp=%h", i, taps_o, exp_t); end
    end
    tick();
    total++;
    if (taps_valid_o !== 1'b0) begin bad++; $display("FAIL delay_pulse_width got=%b exp=0", taps_valid_o); end
    repeat (3) tick();
    total++;
    if (taps_o !== 32'h0002_0005) begin bad++; $display("FAIL delay_hold got=%h exp=00020005", taps_o); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e0;
    logic [NT*DW-1:0] exp_t;
    int cyc;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      strobe(DW'(16'h0100 + i), 8'h0F);
      wait_valid(cyc);
      e0 = (i >= 15) ? DW'(16'h0100 + i - 15) : 16'h0000;
      exp_t = {DW'(16'h0100 + i), e0};
      total++;
      if (taps_o !== exp_t) begin bad++; $display("FAIL wrap_taps[%0d] got=%h exp=%h", i, taps_o, exp_t); end
    end
  endtask

  task automatic test_overrun();
    int cyc;
    do_reset();
    delay_i        = 8'h00;
    sample_i       = 16'h0A0A;
    sample_valid_i = 1'b1;
    tick();
    sample_i = 16'h0B0B;
    tick();
    total++;
    if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun_o); end
    sample_i = 16'h0F0F;
    tick();
    sample_valid_i = 1'b0;
    wait_valid(cyc);
    total++;
    if (cyc !== 1) begin bad++; $display("FAIL overrun_latency got=%0d exp=1", cyc); end
    total++;
    if (taps_o !== 32'h0A0A_0A0A) begin bad++; $display("FAIL overrun_taps got=%h exp=0a0a0a0a", taps_o); end
    total++;
    if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b exp=1", overrun_o); end
    strobe(16'h0C0C, 8'h10);
    wait_valid(cyc);
    total++;
    if (taps_o !== 32'h0A0A_0C0C) begin bad++; $display("FAIL overrun_wrptr got=%h exp=0a0a0c0c", taps_o); end
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    total++;
    if (overrun_o !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", overrun_o); end
    strobe(16'h0D0D, 8'h00);
    sample_valid_i = 1'b1;
    overrun_clr_i  = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    overrun_clr_i  = 1'b0;
    total++;
    if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_set_wins got=%b exp=1", overrun_o); end
    wait_valid(cyc);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    total++;
    if (overrun_o !== 1'b0) begin bad++; $display("FAIL overrun_clear2 got=%b exp=0", overrun_o); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic seen;
    do_reset();
    strobe(16'h0EEE, 8'h00);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (taps_valid_o === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_pulse got=%b exp=0", seen); end
    total++;
    if (taps_o !== '0) begin bad++; $display("FAIL abort_taps got=%h exp=0", taps_o); end
    strobe(16'h0BEE, 8'h10);
    wait_valid(cyc);
    total++;
    if (taps_o !== 32'h0000_0BEE) begin bad++; $display("FAIL abort_fill got=%h exp=00000bee", taps_o); end
  endtask

  task automatic test_delay_latch();
    int cyc;
    strobe(16'h0C01, 8'h00);
    wait_valid(cyc);
    strobe(16'h0C02, 8'h12);
    delay_i = 8'h00;
    wait_valid(cyc);
    total++;
    if (taps_o !== 32'h0C01_0BEE) begin bad++; $display("FAIL latch_taps got=%h exp=0c010bee", taps_o); end
  endtask

  initial begin
    wb_rst_i       = 1'b0;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    delay_i        = '0;
    overrun_clr_i  = 1'b0;
    test_reset();
    test_delay_taps();
    test_wrap();
    test_overrun();
    test_reset_abort();
    test_delay_latch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_multitap_delay_line.md
Name: sram_multitap_delay_line

Overview:
Parametrised successor to the single-channel 1RW1R audio SRAM model. It is a circular sample buffer with NUM_TAPS independently programmable read taps, used as the delay/echo/chorus memory in the pedal DSP chain. Each accepted input sample is written once. All taps are then read back sequentially through one internal synchronous read port, with zero-fill for history that has not yet been written and overrun detection.

Parameters:
DATA_WIDTH, 16, sample width in bits
ADDR_WIDTH, 14, buffer address width; DEPTH = 2**ADDR_WIDTH samples
NUM_TAPS, 2, number of delay taps (1..8)

Ports:
wb_clk_i  input  1  single system clock
wb_rst_i  input  1  synchronous, active-high reset
sample_valid_i  input  1  new sample present; single-cycle strobe
sample_i  input  DATA_WIDTH  input sample, signed two's complement (stored unmodified)
delay_i  input  NUM_TAPS*ADDR_WIDTH  per-tap delay in samples; tap k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
overrun_clr_i  input  1  clears overrun_o
busy_o  output  1  block is processing a sample; new strobes are dropped
taps_valid_o  output  1  one-cycle pulse; taps_o updated
taps_o  output  NUM_TAPS*DATA_WIDTH  tap results; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]
overrun_o  output  1  sticky; a strobe arrived while busy

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: wr_ptr=0, fill=0, FSM=IDLE. busy_o=0, taps_valid_o=0, taps_o=0, overrun_o=0.
- Memory contents are not cleared by reset. Zero-fill via the fill counter replaces clearing.
- Memory: internal array of DEPTH x DATA_WIDTH. Write is synchronous. Read is synchronous: address is registered at edge n, data is available at edge n+1.
- FSM states: IDLE, READ, DONE.
- IDLE, accept edge E0 (sample_valid_i=1):
  - mem[wr_ptr] <= sample_i
  - delay_i latched into internal regs
  - base <= wr_ptr; wr_ptr <= wr_ptr+1 (mod DEPTH)
  - fill <= min(fill+1, DEPTH); fill is ADDR_WIDTH+1 bits wide
  - k <= 0; busy_o <= 1; state -> READ
- READ: at edge E(k+1), register read address (base - delay_k) mod DEPTH, computed as ADDR_WIDTH-bit wrap subtraction. At the next edge, capture the result into tap register k. Reads are pipelined, one tap issued per cycle.
- Zero-fill: if latched delay_k >= fill (post-increment value), tap k result is forced to 0 regardless of memory contents.
- Delay 0 returns the sample written at E0. The write precedes the read by at least one edge, so no bypass is needed.
- Completion: at edge E(NUM_TAPS+1), the last tap is captured. In the same edge, taps_o is updated for all taps at once, taps_valid_o <= 1 for exactly one cycle, busy_o <= 0, and state -> IDLE through DONE.
- Between completions, taps_o holds its value.
- Latency: strobe to taps_valid_o is NUM_TAPS+1 cycles. Minimum strobe spacing is NUM_TAPS+2 cycles.
- Overrun:
  - sample_valid_i while busy_o=1: the sample is dropped and overrun_o <= 1 (sticky).
  - overrun_clr_i=1 clears overrun_o.
  - Simultaneous clear and new overrun: set wins.
- Changing delay_i while busy has no effect on the current sample.
- Reset mid-operation: the FSM aborts to IDLE and all outputs go to their reset values. No taps_valid_o pulse is emitted for the aborted sample.
- wr_ptr wraps DEPTH-1 -> 0. Once fill=DEPTH it stays saturated, and the maximum delay DEPTH-1 returns the oldest stored sample.

Test Plan:
- Reset, then hold idle 10 cycles -> busy_o=0, taps_valid_o=0, taps_o=0, overrun_o=0.
- NUM_TAPS=2, delays {0,3}; strobe samples 0x0001..0x0005 every 4 cycles -> taps_valid_o exactly 3 cycles after each strobe. Tap0 = current sample. Tap1 = 0 for samples 1-3, then 0x0001 and 0x0002.
- ADDR_WIDTH=4 (DEPTH 16), delay 15; write 20 samples 0x0100+i -> after sample 16, tap equals the sample 15 earlier. Wrap at i=16 is correct, with no zero-fill once fill saturates.
- Strobe at E0, then again at E1 and E2 -> second and third samples dropped, overrun_o=1, next wr address unchanged. Assert overrun_clr_i -> overrun_o=0 on the next cycle.
- Strobe, then wb_rst_i at E1 -> no taps_valid_o pulse. After reset, delay {0,1} returns {new sample, 0}, confirming fill restarted.
- Change delay_i at E1 during busy -> results reflect the delays latched at E0.
